seg7_scan_driver: RTL and testbench

- Parametrised multi-digit hex display driver for 7-segment banks with shared segment lines and per-digit enables.
- Holds a double-buffered NUM_DIGITS-nibble value and time-multiplexes one digit at a time.
- Adds decimal points, leading-zero blanking, blink mode, an anti-ghost guard and a frame-done pulse.
- Sits between datapath status/counter outputs and the board display pins.

---
 rtl/seg7_scan_driver.sv | 201 ++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex driver for a bank of 7-segment digits.
// Common segment lines, one active-low enable per digit. The value is
// double-buffered so that each frame shows one consistent value. The block
// adds decimal points, leading-zero blanking, blinking, an anti-ghost blank
// slot and a frame-done pulse.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [6:0]       SEG_OFF  = 7'h7F;

    // Scan and buffer state.
    logic [PRE_W-1:0]      pre_q,       pre_d;
    logic [IDX_W-1:0]      idx_q,       idx_d;
    logic [VAL_W-1:0]      shadow_q,    shadow_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [VAL_W-1:0]      active_q,    active_d;
    logic [NUM_DIGITS-1:0] active_dp_q, active_dp_d;
    logic [BLK_W-1:0]      blk_cnt_q,   blk_cnt_d;
    logic                  blk_off_q,   blk_off_d;

    // Next values of the registered outputs.
    logic [6:0]            seg_d;
    logic                  dp_n_d;
    logic [NUM_DIGITS-1:0] an_d;
    logic                  frame_done_d;

    // Per-cycle decode helpers.
    logic                  slot_end;
    logic                  frame_end;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_lz;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  zero_run;
    logic [NUM_DIGITS-1:0] an_sel;

    // Hex nibble to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h18;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    // Slot/frame boundaries, double-buffer transfer and blink phase.
    always_comb begin
        pre_d       = pre_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        active_d    = active_q;
        active_dp_d = active_dp_q;
        blk_cnt_d   = blk_cnt_q;
        blk_off_d   = blk_off_q;

        slot_end  = (pre_q == PRE_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);

        if (slot_end) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end

        // A load on the boundary bypasses the shadow so it is not lost a frame.
        if (load) begin
            shadow_d    = value;
            shadow_dp_d = dp_in;
        end
        if (frame_end) begin
            active_d    = load ? value : shadow_q;
            active_dp_d = load ? dp_in : shadow_dp_q;
        end

        if (!blink_en) begin
            blk_cnt_d = '0;
            blk_off_d = 1'b0;
        end else if (frame_end) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d = '0;
                blk_off_d = ~blk_off_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
            end
        end
    end

    // Digit select, leading-zero detection and output formatting.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_lz   = 1'b0;

        // Digit i>0 blanks when it and every more-significant nibble are zero.
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run && (active_q[i*4 +: 4] == 4'h0);
            lz_blank[i] = zero_run;
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = active_q[i*4 +: 4];
                cur_dp  = active_dp_q[i];
                cur_lz  = lz_blank[i];
            end
        end

        an_sel = ~(NUM_DIGITS'(1) << idx_q);

        seg_d        = SEG_OFF;
        dp_n_d       = 1'b1;
        an_d         = '1;
        frame_done_d = (pre_q == '0) && (idx_q == '0);

        // First cycle of every slot stays dark so segments settle before an enables.
        if (pre_q != '0) begin
            if (!(blank_lz && cur_lz)) begin
                seg_d = hex7(cur_nib);
            end
            dp_n_d = ~cur_dp;
            if (!(blink_en && blk_off_q)) begin
                an_d = an_sel;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q       <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            active_q    <= '0;
            active_dp_q <= '0;
            blk_cnt_q   <= '0;
            blk_off_q   <= 1'b0;
            seg         <= SEG_OFF;
            dp_n        <= 1'b1;
            an          <= '1;
            frame_done  <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            active_q    <= active_d;
            active_dp_q <= active_dp_d;
            blk_cnt_q   <= blk_cnt_d;
            blk_off_q   <= blk_off_d;
            seg         <= seg_d;
            dp_n        <= dp_n_d;
            an          <= an_d;
            frame_done  <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 4 cycles per slot, 2-frame blink.
module tb_seg7_scan_driver;

    localparam logic [6:0] S0 = 7'h40;
    localparam logic [6:0] S1 = 7'h79;
    localparam logic [6:0] S3 = 7'h30;
    localparam logic [6:0] S7 = 7'h78;
    localparam logic [6:0] SA = 7'h08;
    localparam logic [6:0] SF = 7'h0E;
    localparam logic [6:0] SX = 7'h7F;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        blink_en;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int fnum   = 0;

    seg7_scan_driver #(
        .NUM_DIGITS  (4),
        .CLK_DIV     (4),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .load      (load),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .blink_en  (blink_en),
        .seg       (seg),
        .dp_n      (dp_n),
        .an        (an),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " seg"}, 16'(seg), 16'h007F);
        chk({tag, " an"}, 16'(an), 16'h000F);
        chk({tag, " dp_n"}, 16'(dp_n), 16'h0001);
        chk({tag, " frame_done"}, 16'(frame_done), 16'h0000);
    endtask

    // One 16-cycle frame; eseg holds digit i at [i*7 +: 7], edpn bit i is digit i's dp_n.
    task automatic run_frame(input logic [27:0] eseg, input logic [3:0] edpn, input bit vis,
                             input bit chk_fd, input int ld_at, input logic [15:0] ld_val,
                             input logic [3:0] ld_dp);
        int         slot;
        int         ph;
        logic [3:0] ean;
        logic [6:0] es;
        for (int k = 0; k < 16; k++) begin
            if (k == ld_at) begin
                load  = 1'b1;
                value = ld_val;
                dp_in = ld_dp;
            end
            tick;
            load = 1'b0;
            slot = k / 4;
            ph   = k % 4;
            if (ph == 0) begin
                chk($sformatf("f%0d k%0d guard an", fnum, k), 16'(an), 16'h000F);
                chk($sformatf("f%0d k%0d guard seg", fnum, k), 16'(seg), 16'(SX));
                chk($sformatf("f%0d k%0d guard dp_n", fnum, k), 16'(dp_n), 16'h0001);
                if (chk_fd)
                    chk($sformatf("f%0d k%0d frame_done", fnum, k), 16'(frame_done),
                        (slot == 0) ? 16'h0001 : 16'h0000);
            end else begin
                ean = 4'hF;
                if (vis) ean = ~(4'b0001 << slot);
                chk($sformatf("f%0d k%0d an", fnum, k), 16'(an), 16'(ean));
                if (vis) begin
                    es = eseg[slot*7 +: 7];
                    chk($sformatf("f%0d k%0d seg", fnum, k), 16'(seg), 16'(es));
                    chk($sformatf("f%0d k%0d dp_n", fnum, k), 16'(dp_n), 16'(edpn[slot]));
                end
                if (chk_fd)
                    chk($sformatf("f%0d k%0d frame_done", fnum, k), 16'(frame_done), 16'h0000);
            end
        end
        fnum++;
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        value    = 16'h0000;
        dp_in    = 4'h0;
        blank_lz = 1'b0;
        blink_en = 1'b0;

        // Reset held three cycles; a load during reset must be ignored.
        tick;
        load  = 1'b1;
        value = 16'hFFFF;
        dp_in = 4'hF;
        tick;
        load = 1'b0;
        tick;
        chk_reset_outputs("reset");
        rst = 1'b0;

        // F0 shows zeros; mid-frame load lands in the shadow only.
        run_frame({S0, S0, S0, S0}, 4'hF, 1'b1, 1'b0, 6, 16'h1A3F, 4'b0100);
        // F1 shows 1A3F with digit 2 dp.
        run_frame({S1, SA, S3, SF}, 4'b1011, 1'b1, 1'b1, -1, 16'h0000, 4'h0);
        // F2 still 1A3F; load coincides with the frame boundary.
        run_frame({S1, SA, S3, SF}, 4'b1011, 1'b1, 1'b1, 15, 16'h0007, 4'h0);
        // F3 shows 0007 immediately.
        run_frame({S0, S0, S0, S7}, 4'hF, 1'b1, 1'b1, 2, 16'h0070, 4'h0);

        blank_lz = 1'b1;
        // F4: 0070 with leading zeros blanked.
        run_frame({SX, SX, S7, S0}, 4'hF, 1'b1, 1'b1, 3, 16'h0000, 4'b1000);
        // F5: all zero, only digit 0 lit; blanked digit 3 keeps its dp.
        run_frame({SX, SX, SX, S0}, 4'b0111, 1'b1, 1'b1, -1, 16'h0000, 4'h0);

        blank_lz = 1'b0;
        blink_en = 1'b1;
        // Blink: two frames on, two off, then on again.
        run_frame({S0, S0, S0, S0}, 4'b0111, 1'b1, 1'b1, -1, 16'h0000, 4'h0);
        run_frame({S0, S0, S0, S0}, 4'b0111, 1'b1, 1'b1, -1, 16'h0000, 4'h0);
        run_frame({S0, S0, S0, S0}, 4'b0111, 1'b0, 1'b1, -1, 16'h0000, 4'h0);
        run_frame({S0, S0, S0, S0}, 4'b0111, 1'b0, 1'b1, -1, 16'h0000, 4'h0);
        run_frame({S0, S0, S0, S0}, 4'b0111, 1'b1, 1'b1, -1, 16'h0000, 4'h0);

        blink_en = 1'b0;
        run_frame({S0, S0, S0, S0}, 4'b0111, 1'b1, 1'b1, 0, 16'hFFFF, 4'h0);

        // Next frame shows FFFF; reset in the middle of digit 2's slot.
        repeat (10) tick;
        chk("mid d2 an", 16'(an), 16'h000B);
        chk("mid d2 seg", 16'(seg), 16'(SF));
        chk("mid d2 dp_n", 16'(dp_n), 16'h0001);
        rst = 1'b1;
        tick;
        chk_reset_outputs("midreset");
        rst = 1'b0;

        // Scan restarts at digit 0 with active and shadow cleared.
        run_frame({S0, S0, S0, S0}, 4'hF, 1'b1, 1'b0, -1, 16'h0000, 4'h0);
        run_frame({S0, S0, S0, S0}, 4'hF, 1'b1, 1'b1, -1, 16'h0000, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
